trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and SHALL use an asynchronous, active-high reset: clk is the single clock and rst is the reset, asserted high, acting asynchronously.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock
- rst  in  1  async active-high reset
- id_valid  in  1  ID holds a valid instruction
- inst_ecall  in  1  ID decode flag
- inst_ebreak  in  1  ID decode flag
- inst_mret  in  1  ID decode flag
- irq_timer  in  1  machine timer interrupt pending, already masked by mie.MTIE
- pc_id  in  64  PC of the ID instruction
- mstatus  in  64  current mstatus
- mtvec  in  64  current mtvec (direct mode only)
- mepc  in  64  current mepc
- pipe_idle  in  1  EX/MEM/WB empty, no outstanding AXI transaction
- csr_trap  out  1  forces the decoder to NOP (zero indices)
- stall_if  out  1  freeze PC/IF
- csr_wr_en  out  1  CSR write strobe
- csr_wr_addr  out  12  CSR address
- csr_wr_data  out  64  CSR data
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  64  redirect target
- busy  out  1  FSM not in IDLE

Function
REQ-003 The FSM SHALL have states IDLE, DRAIN, WR_MEPC, WR_MCAUSE, WR_MSTATUS and REDIRECT.
REQ-004 In IDLE, an event SHALL be accepted on a clock edge when id_valid=1 and any of: interrupt (irq_timer & mstatus[3]), inst_ecall, inst_ebreak, inst_mret.
REQ-005 Priority SHALL be interrupt > ecall > ebreak > mret; lower-priority flags in the same cycle are dropped.
REQ-006 On acceptance, the block SHALL latch pc_id, the cause and the kind (trap or mret), and SHALL move to DRAIN.
REQ-007 Cause codes: ecall = 64'd11, ebreak = 64'd3, timer interrupt = 64'h8000_0000_0000_0007.
REQ-008 DRAIN SHALL hold for at least 1 cycle and until pipe_idle=1.
- Trap: DRAIN goes to WR_MEPC.
- mret: DRAIN goes to WR_MSTATUS.
REQ-009 Each WR_* state SHALL last exactly 1 cycle with csr_wr_en=1:
- WR_MEPC: address 12'h341, data = latched PC with bits [1:0] cleared.
- WR_MCAUSE: address 12'h342, data = cause.
- WR_MSTATUS: address 12'h300.
REQ-010 WR_MSTATUS data for a trap SHALL be: MPIE ← MIE, MIE ← 0, MPP ← 2'b11, all other bits from mstatus.
REQ-011 WR_MSTATUS data for mret SHALL be: MIE ← MPIE, MPIE ← 1, MPP ← 2'b11, all other bits from mstatus.
REQ-012 REDIRECT SHALL last 1 cycle with redirect_valid=1, then return to IDLE.
- Trap target: {mtvec[63:2], 2'b00}.
- mret target: mepc sampled in REDIRECT.
REQ-013 csr_trap, stall_if and busy SHALL be registered and SHALL equal (state != IDLE).
REQ-014 Trap latency from acceptance edge to redirect_valid SHALL be 4 cycles + extra DRAIN cycles; mret latency SHALL be 2 cycles + extra DRAIN cycles.
REQ-015 New events SHALL be ignored while busy=1; the decoder flags SHALL NOT be re-sampled until IDLE.
REQ-016 csr_wr_addr and csr_wr_data SHALL be 0 whenever csr_wr_en=0; redirect_pc SHALL be 0 whenever redirect_valid=0.

Reset
REQ-017 rst SHALL force IDLE and drive every output and every latched register to 0 immediately, including mid-sequence; a partial CSR sequence is abandoned and no redirect is issued.
REQ-018 The first event SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-019 Macro TRAP_CTRL_IRQ_EN:
- Defined: irq_timer participates per REQ-004/REQ-005.
- Undefined: irq_timer is ignored and only ecall, ebreak and mret are sequenced.

Structure
REQ-020 FSM state encodings, cause codes, CSR addresses (mepc, mcause, mstatus) and mstatus bit positions SHALL live in the shared defines file.
REQ-021 A combinational sub-module trap_csr_gen SHALL compute the mstatus update and cause value from the latched kind/cause and the current mstatus.

Verification
REQ-022 Bench scenarios (stimulus -> required response):
- ecall at pc_id=0x8000_0010, pipe_idle=1, mtvec=0x8000_1000 -> writes 341←0x8000_0010, 342←11, 300 with MIE=0/MPIE=old MIE/MPP=3; redirect 0x8000_1000 on cycle 4.
- ebreak with pipe_idle low for 5 cycles -> DRAIN held 5 cycles, csr_trap=1 throughout, mcause=3, redirect on cycle 8.
- mret with mstatus.MPIE=1, mepc=0x8000_0200 -> single write to 300 with MIE=1/MPIE=1; redirect 0x8000_0200 on cycle 2.
- irq_timer=1, mstatus.MIE=1 and inst_ecall=1 in the same cycle -> mcause=0x8000_0000_0000_0007 and ecall dropped; with TRAP_CTRL_IRQ_EN undefined -> mcause=11.
- rst asserted during WR_MCAUSE -> all outputs 0 the same cycle, no redirect; an ecall after release runs a full sequence.
- Second ecall presented while busy -> ignored; exactly three CSR writes and one redirect total.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl_pkg
// Description : Shared state encodings, cause codes, CSR addresses and
//               mstatus bit positions for the trap/mret sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_DRAIN      = 3'd1;
  localparam state_t S_WR_MEPC    = 3'd2;
  localparam state_t S_WR_MCAUSE  = 3'd3;
  localparam state_t S_WR_MSTATUS = 3'd4;
  localparam state_t S_REDIRECT   = 3'd5;

  typedef enum logic [1:0] {
    CAUSE_NONE      = 2'd0,
    CAUSE_ECALL     = 2'd1,
    CAUSE_EBREAK    = 2'd2,
    CAUSE_IRQ_TIMER = 2'd3
  } cause_t;

  localparam logic [63:0] C_CAUSE_ECALL     = 64'd11;
  localparam logic [63:0] C_CAUSE_EBREAK    = 64'd3;
  localparam logic [63:0] C_CAUSE_IRQ_TIMER = 64'h8000_0000_0000_0007;

  localparam logic [11:0] C_CSR_MSTATUS = 12'h300;
  localparam logic [11:0] C_CSR_MEPC    = 12'h341;
  localparam logic [11:0] C_CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  function automatic logic [63:0] cause_code(input cause_t cause);
    logic [63:0] code;
    code = 64'd0;
    case (cause)
      CAUSE_ECALL:     code = C_CAUSE_ECALL;
      CAUSE_EBREAK:    code = C_CAUSE_EBREAK;
      CAUSE_IRQ_TIMER: code = C_CAUSE_IRQ_TIMER;
      default:         code = 64'd0;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_csr_gen.sv
`default_nettype none
// ============================================================================
// Module      : trap_csr_gen
// Description : Combinational mstatus update and mcause value generator.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_csr_gen
  import trap_ctrl_pkg::*;
(
  input  logic        is_mret,
  input  cause_t      cause,
  input  logic [63:0] mstatus,
  output logic [63:0] mstatus_nxt,
  output logic [63:0] cause_val
);

  always_comb begin
    mstatus_nxt = mstatus;
    if (is_mret) begin
      mstatus_nxt[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
      mstatus_nxt[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_nxt[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
      mstatus_nxt[MSTATUS_MIE]  = 1'b0;
    end
    mstatus_nxt[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  assign cause_val = cause_code(cause);

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Trap/mret sequencer: drains the pipe, writes mepc/mcause/
//               mstatus and redirects the PC. Define TRAP_CTRL_IRQ_EN to let
//               the machine timer interrupt take part.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        inst_ecall,
  input  logic        inst_ebreak,
  input  logic        inst_mret,
  input  logic        irq_timer,
  input  logic [63:0] pc_id,
  input  logic [63:0] mstatus,
  input  logic [63:0] mtvec,
  input  logic [63:0] mepc,
  input  logic        pipe_idle,
  output logic        csr_trap,
  output logic        stall_if,
  output logic        csr_wr_en,
  output logic [11:0] csr_wr_addr,
  output logic [63:0] csr_wr_data,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        busy
);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_busy;
  logic [63:0] r_pc;
  cause_t      r_cause;
  logic        r_is_mret;

  logic        w_irq;
  logic        w_accept;
  cause_t      w_cause;
  logic        w_is_mret;
  logic [63:0] w_mstatus_nxt;
  logic [63:0] w_cause_val;

`ifdef TRAP_CTRL_IRQ_EN
  assign w_irq = irq_timer & mstatus[MSTATUS_MIE];
`else
  logic w_unused_irq;
  assign w_unused_irq = irq_timer;
  assign w_irq        = 1'b0;
`endif

  // Priority encode; lower-priority flags in the same cycle are dropped
  always_comb begin
    w_cause   = CAUSE_NONE;
    w_is_mret = 1'b0;
    if (w_irq)            w_cause   = CAUSE_IRQ_TIMER;
    else if (inst_ecall)  w_cause   = CAUSE_ECALL;
    else if (inst_ebreak) w_cause   = CAUSE_EBREAK;
    else if (inst_mret)   w_is_mret = 1'b1;
  end

  assign w_accept = id_valid & (w_irq | inst_ecall | inst_ebreak | inst_mret);

  trap_csr_gen u_csr_gen (
    .is_mret     (r_is_mret),
    .cause       (r_cause),
    .mstatus     (mstatus),
    .mstatus_nxt (w_mstatus_nxt),
    .cause_val   (w_cause_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_pc      <= 64'd0;
      r_cause   <= CAUSE_NONE;
      r_is_mret <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      if ((r_state == S_IDLE) && w_accept) begin
        r_pc      <= pc_id;
        r_cause   <= w_cause;
        r_is_mret <= w_is_mret;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:       if (w_accept) w_next_state = S_DRAIN;
      S_DRAIN:      if (pipe_idle) w_next_state = r_is_mret ? S_WR_MSTATUS : S_WR_MEPC;
      S_WR_MEPC:    w_next_state = S_WR_MCAUSE;
      S_WR_MCAUSE:  w_next_state = S_WR_MSTATUS;
      S_WR_MSTATUS: w_next_state = S_REDIRECT;
      S_REDIRECT:   w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    csr_wr_en      = 1'b0;
    csr_wr_addr    = 12'd0;
    csr_wr_data    = 64'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    case (r_state)
      S_WR_MEPC: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = C_CSR_MEPC;
        csr_wr_data = r_pc & ~64'h3;
      end
      S_WR_MCAUSE: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = C_CSR_MCAUSE;
        csr_wr_data = w_cause_val;
      end
      S_WR_MSTATUS: begin
        csr_wr_en   = 1'b1;
        csr_wr_addr = C_CSR_MSTATUS;
        csr_wr_data = w_mstatus_nxt;
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_is_mret ? mepc : (mtvec & ~64'h3);
      end
      default: ;
    endcase
  end

  assign csr_trap = r_busy;
  assign stall_if = r_busy;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Directed self-checking bench for trap_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, inst_ecall, inst_ebreak, inst_mret, irq_timer;
  logic [63:0] pc_id, mstatus, mtvec, mepc;
  logic        pipe_idle;
  logic        csr_trap, stall_if, csr_wr_en, redirect_valid, busy;
  logic [11:0] csr_wr_addr;
  logic [63:0] csr_wr_data, redirect_pc;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int redir_cnt = 0;
  int wc0, rc0;

`ifdef TRAP_CTRL_IRQ_EN
  localparam logic [63:0] EXP_IRQ_CAUSE = 64'h8000_0000_0000_0007;
`else
  localparam logic [63:0] EXP_IRQ_CAUSE = 64'd11;
`endif

  trap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .inst_ecall     (inst_ecall),
    .inst_ebreak    (inst_ebreak),
    .inst_mret      (inst_mret),
    .irq_timer      (irq_timer),
    .pc_id          (pc_id),
    .mstatus        (mstatus),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .pipe_idle      (pipe_idle),
    .csr_trap       (csr_trap),
    .stall_if       (stall_if),
    .csr_wr_en      (csr_wr_en),
    .csr_wr_addr    (csr_wr_addr),
    .csr_wr_data    (csr_wr_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (csr_wr_en)      wr_cnt    <= wr_cnt + 1;
    if (redirect_valid) redir_cnt <= redir_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_flags();
    id_valid    = 1'b0;
    inst_ecall  = 1'b0;
    inst_ebreak = 1'b0;
    inst_mret   = 1'b0;
    irq_timer   = 1'b0;
  endtask

  task automatic expect_cyc(input string tag, input logic b, input logic we,
                            input logic [11:0] a, input logic [63:0] d,
                            input logic rv, input logic [63:0] rp);
    chk({tag, ".busy"},     64'(busy),           64'(b));
    chk({tag, ".csr_trap"}, 64'(csr_trap),       64'(b));
    chk({tag, ".stall_if"}, 64'(stall_if),       64'(b));
    chk({tag, ".wr_en"},    64'(csr_wr_en),      64'(we));
    chk({tag, ".wr_addr"},  64'(csr_wr_addr),    64'(a));
    chk({tag, ".wr_data"},  csr_wr_data,         d);
    chk({tag, ".rd_valid"}, 64'(redirect_valid), 64'(rv));
    chk({tag, ".rd_pc"},    redirect_pc,         rp);
  endtask

  initial begin
    rst = 1'b1;
    clr_flags();
    pc_id = 64'd0; mstatus = 64'd0; mtvec = 64'd0; mepc = 64'd0;
    pipe_idle = 1'b1;
    step(); step();
    expect_cyc("reset", 0, 0, 12'h0, 64'h0, 0, 64'h0);
    rst = 1'b0;
    step();
    expect_cyc("idle", 0, 0, 12'h0, 64'h0, 0, 64'h0);

    // ecall, pipe already idle
    mstatus = 64'h8; mtvec = 64'h8000_1000; pc_id = 64'h8000_0010;
    id_valid = 1'b1; inst_ecall = 1'b1;
    step(); clr_flags();
    expect_cyc("ec.drain",  1, 0, 12'h000, 64'h0, 0, 64'h0);
    step(); expect_cyc("ec.mepc",   1, 1, 12'h341, 64'h8000_0010, 0, 64'h0);
    step(); expect_cyc("ec.mcause", 1, 1, 12'h342, 64'd11, 0, 64'h0);
    step(); expect_cyc("ec.mstat",  1, 1, 12'h300, 64'h1880, 0, 64'h0);
    step(); expect_cyc("ec.redir",  1, 0, 12'h000, 64'h0, 1, 64'h8000_1000);
    step(); expect_cyc("ec.done",   0, 0, 12'h000, 64'h0, 0, 64'h0);

    // ebreak (with mret dropped), pipe busy so DRAIN lasts 5 cycles
    mstatus = 64'h0; mtvec = 64'h8000_1003; pc_id = 64'h8000_0043;
    pipe_idle = 1'b0;
    id_valid = 1'b1; inst_ebreak = 1'b1; inst_mret = 1'b1;
    step(); clr_flags();
    for (int i = 0; i < 4; i++) begin
      expect_cyc("eb.drain", 1, 0, 12'h000, 64'h0, 0, 64'h0);
      step();
    end
    expect_cyc("eb.drain5", 1, 0, 12'h000, 64'h0, 0, 64'h0);
    pipe_idle = 1'b1;
    step(); expect_cyc("eb.mepc",   1, 1, 12'h341, 64'h8000_0040, 0, 64'h0);
    step(); expect_cyc("eb.mcause", 1, 1, 12'h342, 64'd3, 0, 64'h0);
    step(); expect_cyc("eb.mstat",  1, 1, 12'h300, 64'h1800, 0, 64'h0);
    step(); expect_cyc("eb.redir",  1, 0, 12'h000, 64'h0, 1, 64'h8000_1000);
    step(); expect_cyc("eb.done",   0, 0, 12'h000, 64'h0, 0, 64'h0);

    // mret
    mstatus = 64'h80; mepc = 64'h8000_0200;
    id_valid = 1'b1; inst_mret = 1'b1;
    step(); clr_flags();
    expect_cyc("mr.drain", 1, 0, 12'h000, 64'h0, 0, 64'h0);
    step(); expect_cyc("mr.mstat", 1, 1, 12'h300, 64'h1888, 0, 64'h0);
    step(); expect_cyc("mr.redir", 1, 0, 12'h000, 64'h0, 1, 64'h8000_0200);
    step(); expect_cyc("mr.done",  0, 0, 12'h000, 64'h0, 0, 64'h0);

    // no acceptance without id_valid, or with a masked interrupt alone
    inst_ecall = 1'b1;
    step(); expect_cyc("noval", 0, 0, 12'h000, 64'h0, 0, 64'h0);
    clr_flags();
    mstatus = 64'h0; id_valid = 1'b1; irq_timer = 1'b1;
    step(); expect_cyc("irqmask", 0, 0, 12'h000, 64'h0, 0, 64'h0);
    clr_flags();

    // timer interrupt together with ecall
    mstatus = 64'h8; mtvec = 64'h8000_1000; pc_id = 64'h8000_0080;
    id_valid = 1'b1; irq_timer = 1'b1; inst_ecall = 1'b1;
    step(); clr_flags();
    step(); expect_cyc("irq.mepc",   1, 1, 12'h341, 64'h8000_0080, 0, 64'h0);
    step(); expect_cyc("irq.mcause", 1, 1, 12'h342, EXP_IRQ_CAUSE, 0, 64'h0);
    step(); expect_cyc("irq.mstat",  1, 1, 12'h300, 64'h1880, 0, 64'h0);
    step(); expect_cyc("irq.redir",  1, 0, 12'h000, 64'h0, 1, 64'h8000_1000);
    step();

    // reset in the middle of WR_MCAUSE
    mstatus = 64'h0; pc_id = 64'h8000_0100;
    id_valid = 1'b1; inst_ecall = 1'b1;
    step(); clr_flags();
    step(); step();
    expect_cyc("rs.mcause", 1, 1, 12'h342, 64'd11, 0, 64'h0);
    rc0 = redir_cnt;
    #1 rst = 1'b1;
    #1 expect_cyc("rs.async", 0, 0, 12'h000, 64'h0, 0, 64'h0);
    step(); step();
    expect_cyc("rs.held", 0, 0, 12'h000, 64'h0, 0, 64'h0);
    rst = 1'b0;
    mstatus = 64'h8;
    id_valid = 1'b1; inst_ecall = 1'b1;
    step(); clr_flags();
    chk("rs.no_redir", 64'(redir_cnt - rc0), 64'd0);
    expect_cyc("rs2.drain",  1, 0, 12'h000, 64'h0, 0, 64'h0);
    step(); expect_cyc("rs2.mepc",   1, 1, 12'h341, 64'h8000_0100, 0, 64'h0);
    step(); expect_cyc("rs2.mcause", 1, 1, 12'h342, 64'd11, 0, 64'h0);
    step(); expect_cyc("rs2.mstat",  1, 1, 12'h300, 64'h1880, 0, 64'h0);
    step(); expect_cyc("rs2.redir",  1, 0, 12'h000, 64'h0, 1, 64'h8000_1000);
    step();

    // ecall held asserted while busy must not restart the sequence
    wc0 = wr_cnt; rc0 = redir_cnt;
    pc_id = 64'h8000_0300;
    id_valid = 1'b1; inst_ecall = 1'b1;
    step();
    step(); expect_cyc("bz.mepc", 1, 1, 12'h341, 64'h8000_0300, 0, 64'h0);
    pc_id = 64'h8000_0400;
    step(); step();
    step(); expect_cyc("bz.redir", 1, 0, 12'h000, 64'h0, 1, 64'h8000_1000);
    clr_flags();
    step(); expect_cyc("bz.done", 0, 0, 12'h000, 64'h0, 0, 64'h0);
    step();
    chk("bz.writes", 64'(wr_cnt - wc0),    64'd3);
    chk("bz.redirs", 64'(redir_cnt - rc0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
